// File: rtl/spu_pkg.sv
// Shared types and element helpers for the SPU even-pipe shift/rotate stage.
// Element helpers take the raw 16-bit count and apply the per-op mask themselves.
package spu_pkg;

    localparam int SPU_DATA_W = 128;
    localparam int SPU_ADDR_W = 7;

    typedef enum logic [2:0] {
        SHLH, SHLHI, SHL, SHLI, ROTH, ROTHI, ROT, ROTI
    } op_e;

    typedef struct packed {
        logic                  valid;
        logic [SPU_ADDR_W-1:0] rt;
        logic [SPU_DATA_W-1:0] data;
    } sf2_stage_t;

    // Counts of 16 or more (halfword) / 32 or more (word) clear the element.
    function automatic logic [15:0] shl16(input logic [15:0] x, input logic [15:0] cnt);
        return cnt[4] ? 16'h0000 : (x << cnt[3:0]);
    endfunction

    function automatic logic [31:0] shl32(input logic [31:0] x, input logic [15:0] cnt);
        return cnt[5] ? 32'h0000_0000 : (x << cnt[4:0]);
    endfunction

    function automatic logic [15:0] rot16(input logic [15:0] x, input logic [15:0] cnt);
        logic [31:0] t;
        t = {x, x} << cnt[3:0];
        return t[31:16];
    endfunction

    function automatic logic [31:0] rot32(input logic [31:0] x, input logic [15:0] cnt);
        logic [63:0] t;
        t = {x, x} << cnt[4:0];
        return t[63:32];
    endfunction

endpackage

// File: rtl/sf2_shift_rotate_alu.sv
// Combinational halfword/word shift and rotate, big-endian element numbering.
// Register forms take each element's count from the same slot of rb.
module sf2_shift_rotate_alu
    import spu_pkg::*;
#(
    parameter int DATA_W = SPU_DATA_W
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] rb,
    input  logic [6:0]        imm7,
    output logic [DATA_W-1:0] result
);

    logic [15:0] imm_cnt;

    assign imm_cnt = {{9{imm7[6]}}, imm7};

    always_comb begin
        result = '0;
        for (int k = 0; k < DATA_W / 16; k++) begin
            case (op)
                SHLH:    result[DATA_W-1-16*k -: 16] = shl16(ra[DATA_W-1-16*k -: 16], rb[DATA_W-1-16*k -: 16]);
                SHLHI:   result[DATA_W-1-16*k -: 16] = shl16(ra[DATA_W-1-16*k -: 16], imm_cnt);
                ROTH:    result[DATA_W-1-16*k -: 16] = rot16(ra[DATA_W-1-16*k -: 16], rb[DATA_W-1-16*k -: 16]);
                ROTHI:   result[DATA_W-1-16*k -: 16] = rot16(ra[DATA_W-1-16*k -: 16], imm_cnt);
                default: ;
            endcase
        end
        // Word counts live in the low halfword of each rb word.
        for (int k = 0; k < DATA_W / 32; k++) begin
            case (op)
                SHL:     result[DATA_W-1-32*k -: 32] = shl32(ra[DATA_W-1-32*k -: 32], rb[DATA_W-17-32*k -: 16]);
                SHLI:    result[DATA_W-1-32*k -: 32] = shl32(ra[DATA_W-1-32*k -: 32], imm_cnt);
                ROT:     result[DATA_W-1-32*k -: 32] = rot32(ra[DATA_W-1-32*k -: 32], rb[DATA_W-17-32*k -: 16]);
                ROTI:    result[DATA_W-1-32*k -: 32] = rot32(ra[DATA_W-1-32*k -: 32], imm_cnt);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sf2_shift_rotate_pipe.sv
// Simple-fixed-2 execution stage: result formed in stage 1, copied down a
// fixed-depth pipe to writeback, with per-stage forwarding taps.
module sf2_shift_rotate_pipe
    import spu_pkg::*;
#(
    parameter int LATENCY = 4,
    // Stage storage uses sf2_stage_t, so these must match the package widths.
    parameter int DATA_W  = SPU_DATA_W,
    parameter int ADDR_W  = SPU_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  op_e                       issue_op,
    input  logic [DATA_W-1:0]         issue_ra,
    input  logic [DATA_W-1:0]         issue_rb,
    input  logic [6:0]                issue_imm7,
    input  logic [ADDR_W-1:0]         issue_rt,
    input  logic                      flush,
    output logic [LATENCY-1:0]        fw_valid,
    output logic [LATENCY*ADDR_W-1:0] fw_rt,
    output logic [LATENCY*DATA_W-1:0] fw_data,
    output logic                      wb_valid,
    output logic [ADDR_W-1:0]         wb_rt,
    output logic [DATA_W-1:0]         wb_data
);

    logic [DATA_W-1:0] alu_result;
    logic              accept;
    sf2_stage_t        stage [1:LATENCY];

    sf2_shift_rotate_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (issue_op),
        .ra     (issue_ra),
        .rb     (issue_rb),
        .imm7   (issue_imm7),
        .result (alu_result)
    );

    assign accept = issue_valid && !flush;

    // NOTE: state is updated with non-blocking assignments so every stage samples
    // its predecessor's pre-edge value; blocking here would collapse the pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: rt/data flops are reset too, so the taps read 0 out of reset
            // rather than X; they are plain registers, not an inferred RAM.
            for (int s = 1; s <= LATENCY; s++) stage[s] <= '0;
        end else begin
            stage[1].valid <= accept;
            if (accept) begin
                stage[1].rt   <= issue_rt;
                stage[1].data <= alu_result;
            end
            for (int s = 2; s <= LATENCY; s++) begin
                // Flush kills everything that lands short of the final stage.
                stage[s].valid <= stage[s-1].valid && (!flush || s == LATENCY);
                if (stage[s-1].valid) begin
                    stage[s].rt   <= stage[s-1].rt;
                    stage[s].data <= stage[s-1].data;
                end
            end
        end
    end

    for (genvar s = 1; s <= LATENCY; s++) begin : g_tap
        assign fw_valid[s-1]                  = stage[s].valid;
        assign fw_rt[(s-1)*ADDR_W +: ADDR_W]   = stage[s].rt;
        assign fw_data[(s-1)*DATA_W +: DATA_W] = stage[s].data;
    end

    assign wb_valid = stage[LATENCY].valid;
    assign wb_rt    = stage[LATENCY].rt;
    assign wb_data  = stage[LATENCY].data;

endmodule

// File: tb/tb_sf2_shift_rotate_pipe.sv
// Directed bench for sf2_shift_rotate_pipe: op results, latency, streaming,
// flush and mid-flight reset, all against hand-computed expectations.
module tb_sf2_shift_rotate_pipe;
    import spu_pkg::*;

    localparam int LATENCY = 4;
    localparam int DATA_W  = 128;
    localparam int ADDR_W  = 7;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      issue_valid;
    op_e                       issue_op;
    logic [DATA_W-1:0]         issue_ra;
    logic [DATA_W-1:0]         issue_rb;
    logic [6:0]                issue_imm7;
    logic [ADDR_W-1:0]         issue_rt;
    logic                      flush;
    logic [LATENCY-1:0]        fw_valid;
    logic [LATENCY*ADDR_W-1:0] fw_rt;
    logic [LATENCY*DATA_W-1:0] fw_data;
    logic                      wb_valid;
    logic [ADDR_W-1:0]         wb_rt;
    logic [DATA_W-1:0]         wb_data;

    int total = 0;
    int bad   = 0;

    // Expected-pipe occupancy for the streaming tests (index 0 = stage 1).
    logic              m_v  [LATENCY];
    logic [ADDR_W-1:0] m_rt [LATENCY];

    sf2_shift_rotate_pipe #(.LATENCY(LATENCY), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_ra    (issue_ra),
        .issue_rb    (issue_rb),
        .issue_imm7  (issue_imm7),
        .issue_rt    (issue_rt),
        .flush       (flush),
        .fw_valid    (fw_valid),
        .fw_rt       (fw_rt),
        .fw_data     (fw_data),
        .wb_valid    (wb_valid),
        .wb_rt       (wb_rt),
        .wb_data     (wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rep16(input logic [15:0] h);
        return {8{h}};
    endfunction

    function automatic logic [127:0] rep32(input logic [31:0] w);
        return {4{w}};
    endfunction

    // Streaming tests use SHLHI by 1 on a pattern keyed by rt, so data follows from rt.
    function automatic logic [127:0] stream_ra(input logic [ADDR_W-1:0] rt);
        return rep16(16'h0100 + 16'(rt));
    endfunction

    function automatic logic [127:0] stream_res(input logic [ADDR_W-1:0] rt);
        return rep16(16'h0200 + (16'(rt) << 1));
    endfunction

    task automatic idle();
        issue_valid = 1'b0;
        flush       = 1'b0;
        issue_op    = SHLH;
        issue_ra    = '0;
        issue_rb    = '0;
        issue_imm7  = '0;
        issue_rt    = '0;
    endtask

    task automatic drive(input op_e op, input logic [127:0] ra, input logic [127:0] rb,
                         input logic [6:0] imm, input logic [ADDR_W-1:0] rt);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_ra    = ra;
        issue_rb    = rb;
        issue_imm7  = imm;
        issue_rt    = rt;
    endtask

    // Issue one op and report what writes back; lat counts edges after acceptance (-1 = timeout).
    task automatic send_and_wait(input op_e op, input logic [127:0] ra, input logic [127:0] rb,
                                 input logic [6:0] imm, input logic [ADDR_W-1:0] rt,
                                 output logic [127:0] d, output logic [ADDR_W-1:0] ort,
                                 output int lat, output logic strobe_after);
        drive(op, ra, rb, imm, rt);
        @(posedge clk);
        @(negedge clk);
        idle();
        lat = 0;
        while (!wb_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!wb_valid) lat = -1;
        d   = wb_data;
        ort = wb_rt;
        @(posedge clk);
        @(negedge clk);
        strobe_after = wb_valid;
    endtask

    task automatic model_clear();
        for (int s = 0; s < LATENCY; s++) begin
            m_v[s]  = 1'b0;
            m_rt[s] = '0;
        end
    endtask

    task automatic model_step(input logic v, input logic [ADDR_W-1:0] rt, input logic fl);
        for (int s = LATENCY - 1; s > 0; s--) begin
            m_rt[s] = m_rt[s-1];
            m_v[s]  = m_v[s-1] && (!fl || s == LATENCY - 1);
        end
        m_v[0]  = v && !fl;
        m_rt[0] = rt;
    endtask

    function automatic logic [LATENCY-1:0] model_valids();
        logic [LATENCY-1:0] r;
        for (int s = 0; s < LATENCY; s++) r[s] = m_v[s];
        return r;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total += 4;
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0b want=0", wb_valid); end
        if (fw_valid !== '0) begin bad++; $display("FAIL rst_fw_valid got=%b want=0", fw_valid); end
        if (wb_data !== '0 || wb_rt !== '0) begin bad++; $display("FAIL rst_wb_fields got=%h/%h want=0", wb_rt, wb_data); end
        if (fw_data !== '0 || fw_rt !== '0) begin bad++; $display("FAIL rst_fw_fields got=%h want=0", fw_rt); end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total += 2;
        if (wb_valid !== 1'b0 || fw_valid !== '0) begin
            bad++; $display("FAIL post_rst_valids got=%0b/%b want=0/0", wb_valid, fw_valid);
        end
        if (wb_data !== '0 || fw_data !== '0 || fw_rt !== '0) begin
            bad++; $display("FAIL post_rst_fields got=%h want=0", wb_data);
        end
    endtask

    task automatic test_shlhi();
        logic [127:0] d; logic [ADDR_W-1:0] rt; int lat; logic after;
        send_and_wait(SHLHI, rep16(16'h8001), '0, 7'h01, 7'd10, d, rt, lat, after);
        total += 4;
        if (lat !== LATENCY - 1) begin bad++; $display("FAIL shlhi_latency got=%0d want=%0d", lat, LATENCY - 1); end
        if (d !== rep16(16'h0002)) begin bad++; $display("FAIL shlhi_data got=%h want=%h", d, rep16(16'h0002)); end
        if (rt !== 7'd10) begin bad++; $display("FAIL shlhi_rt got=%0d want=10", rt); end
        if (after !== 1'b0) begin bad++; $display("FAIL shlhi_strobe_width got=%0b want=0", after); end
        // imm7 0x50 sign-extends to 0xFFD0; masked count 16 clears every halfword.
        send_and_wait(SHLHI, rep16(16'h1234), '0, 7'h50, 7'd11, d, rt, lat, after);
        total++;
        if (d !== '0) begin bad++; $display("FAIL shlhi_neg_imm got=%h want=0", d); end
    endtask

    task automatic test_shlh();
        logic [127:0] d; logic [ADDR_W-1:0] rt; int lat; logic after;
        logic [127:0] rb, exp;
        rb  = {16'd0, 16'd1, 16'd15, 16'd16, 16'd17, 16'd31, 16'd32, 16'h001F};
        exp = {16'hFFFF, 16'hFFFE, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        send_and_wait(SHLH, rep16(16'hFFFF), rb, 7'h00, 7'd20, d, rt, lat, after);
        total++;
        if (d !== exp) begin bad++; $display("FAIL shlh_counts got=%h want=%h", d, exp); end
    endtask

    task automatic test_shl();
        logic [127:0] d; logic [ADDR_W-1:0] rt; int lat; logic after;
        logic [127:0] rb, exp;
        send_and_wait(SHLI, rep32(32'hFFFF_FFFF), '0, 7'h7F, 7'd30, d, rt, lat, after);
        total++;
        if (d !== '0) begin bad++; $display("FAIL shli_63 got=%h want=0", d); end
        rb  = {32'd31, 32'd32, 32'd33, 32'd5};
        exp = {32'h8000_0000, 32'h0, 32'h0, 32'h0000_0020};
        send_and_wait(SHL, rep32(32'h0000_0001), rb, 7'h00, 7'd31, d, rt, lat, after);
        total++;
        if (d !== exp) begin bad++; $display("FAIL shl_counts got=%h want=%h", d, exp); end
    endtask

    task automatic test_rotate();
        logic [127:0] d; logic [ADDR_W-1:0] rt; int lat; logic after;
        logic [127:0] rb, exp;
        send_and_wait(ROTI, rep32(32'hF000_0001), '0, 7'h04, 7'd40, d, rt, lat, after);
        total++;
        if (d !== rep32(32'h0000_001F)) begin bad++; $display("FAIL roti_4 got=%h want=%h", d, rep32(32'h0000_001F)); end
        rb  = {16'd0, 16'd1, 16'd4, 16'd15, 16'd16, 16'd17, 16'd8, 16'hFFFF};
        exp = {16'h8001, 16'h0003, 16'h0018, 16'hC000, 16'h8001, 16'h0003, 16'h0180, 16'hC000};
        send_and_wait(ROTH, rep16(16'h8001), rb, 7'h00, 7'd41, d, rt, lat, after);
        total++;
        if (d !== exp) begin bad++; $display("FAIL roth_counts got=%h want=%h", d, exp); end
        rb  = {32'd0, 32'd1, 32'd32, 32'd63};
        exp = {32'h8000_0001, 32'h0000_0003, 32'h8000_0001, 32'hC000_0000};
        send_and_wait(ROT, rep32(32'h8000_0001), rb, 7'h00, 7'd42, d, rt, lat, after);
        total++;
        if (d !== exp) begin bad++; $display("FAIL rot_counts got=%h want=%h", d, exp); end
    endtask

    task automatic test_back_to_back();
        int seen;
        seen = 0;
        model_clear();
        for (int c = 0; c < 8 + LATENCY + 1; c++) begin
            if (c < 8) drive(SHLHI, stream_ra(7'(c + 1)), '0, 7'h01, 7'(c + 1));
            else idle();
            @(posedge clk);
            model_step(c < 8, 7'(c + 1), 1'b0);
            @(negedge clk);
            total += 2;
            if (fw_valid !== model_valids()) begin
                bad++; $display("FAIL b2b_fw_valid c=%0d got=%b want=%b", c, fw_valid, model_valids());
            end
            if (wb_valid !== m_v[LATENCY-1]) begin
                bad++; $display("FAIL b2b_wb_valid c=%0d got=%0b want=%0b", c, wb_valid, m_v[LATENCY-1]);
            end
            for (int s = 0; s < LATENCY; s++) begin
                if (m_v[s]) begin
                    total++;
                    if (fw_rt[s*ADDR_W +: ADDR_W] !== m_rt[s]) begin
                        bad++; $display("FAIL b2b_fw_rt c=%0d s=%0d got=%0d want=%0d", c, s + 1, fw_rt[s*ADDR_W +: ADDR_W], m_rt[s]);
                    end
                end
            end
            if (m_v[LATENCY-1]) begin
                seen++;
                total += 2;
                if (wb_rt !== 7'(seen)) begin bad++; $display("FAIL b2b_wb_rt got=%0d want=%0d", wb_rt, seen); end
                if (wb_data !== stream_res(7'(seen))) begin
                    bad++; $display("FAIL b2b_wb_data got=%h want=%h", wb_data, stream_res(7'(seen)));
                end
            end
        end
        idle();
        total++;
        if (seen !== 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", seen); end
    endtask

    task automatic test_flush();
        int seen;
        logic [ADDR_W-1:0] last_rt;
        seen = 0;
        last_rt = '0;
        model_clear();
        for (int c = 0; c < 4 + LATENCY + 1; c++) begin
            if (c < 4) drive(SHLHI, stream_ra(7'(c + 1)), '0, 7'h01, 7'(c + 1));
            else idle();
            flush = (c == 2);
            @(posedge clk);
            model_step(c < 4, 7'(c + 1), c == 2);
            @(negedge clk);
            flush = 1'b0;
            total += 2;
            if (fw_valid !== model_valids()) begin
                bad++; $display("FAIL flush_fw_valid c=%0d got=%b want=%b", c, fw_valid, model_valids());
            end
            if (wb_valid !== m_v[LATENCY-1]) begin
                bad++; $display("FAIL flush_wb_valid c=%0d got=%0b want=%0b", c, wb_valid, m_v[LATENCY-1]);
            end
            if (wb_valid) begin
                seen++;
                last_rt = wb_rt;
                total++;
                if (wb_data !== stream_res(wb_rt)) begin
                    bad++; $display("FAIL flush_wb_data got=%h want=%h", wb_data, stream_res(wb_rt));
                end
            end
        end
        idle();
        total += 2;
        if (seen !== 1) begin bad++; $display("FAIL flush_count got=%0d want=1", seen); end
        if (last_rt !== 7'd4) begin bad++; $display("FAIL flush_survivor_rt got=%0d want=4", last_rt); end
    endtask

    task automatic test_reset_inflight();
        int seen;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            drive(SHLHI, stream_ra(7'(50 + c)), '0, 7'h01, 7'(50 + c));
            @(posedge clk);
            @(negedge clk);
        end
        idle();
        total++;
        if (fw_valid !== 3'b111) begin bad++; $display("FAIL rst_fl_preload got=%b want=0111", fw_valid); end
        #2 rst = 1'b1;
        #1;
        total += 2;
        if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_fl_wb_valid got=%0b want=0", wb_valid); end
        if (fw_valid !== '0) begin bad++; $display("FAIL rst_fl_fw_valid got=%b want=0", fw_valid); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < LATENCY + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (wb_valid || fw_valid !== '0) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rst_fl_no_wb got=%0d want=0", seen); end
    endtask

    initial begin
        idle();
        test_reset();
        test_shlhi();
        test_shlh();
        test_shl();
        test_rotate();
        test_back_to_back();
        test_flush();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
